// File: rtl/word_parser.sv
// Tokenizer front end: skips delimiters in the TIB, copies one token to memory as a counted string.
// Optional WORD_PARSER_WS_EN: with a space delimiter, every byte <= 0x20 also counts as a delimiter.
module word_parser #(
    parameter int DSZ     = 8,
    parameter int ASZ     = 17,
    parameter int MAX_LEN = 31
) (
    input  logic           clk,
    input  logic           rst,
    output logic [ASZ-1:0] mb_ai_o,
    output logic [DSZ-1:0] mb_vi_o,
    output logic           mb_we_o,
    input  logic [DSZ-1:0] vw_i,
    input  logic           en_i,
    input  logic [ASZ-1:0] tib_i,
    input  logic [DSZ-1:0] ntib_i,
    input  logic [DSZ-1:0] toi_i,
    input  logic [ASZ-1:0] dst_i,
    input  logic [DSZ-1:0] delim_i,
    output logic           bsy_o,
    output logic           done_o,
    output logic [ASZ-1:0] aw_o,
    output logic [DSZ-1:0] len_o,
    output logic [DSZ-1:0] toin_o,
    output logic           nul_o,
    output logic           ovf_o,
    output logic [2:0]     state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SKP_RD = 3'd1,
        SKP_CK = 3'd2,
        CPY_WR = 3'd3,
        CPY_RD = 3'd4,
        CPY_CK = 3'd5,
        LEN_WR = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam logic [DSZ-1:0] MAX_LEN_W = DSZ'(MAX_LEN);
    localparam logic [DSZ-1:0] SPACE     = DSZ'(32);

    state_t         state_q, state_d;
    logic [ASZ-1:0] tib_q, tib_d;
    logic [DSZ-1:0] ntib_q, ntib_d;
    logic [DSZ-1:0] i_q, i_d;
    logic [ASZ-1:0] aw_q, aw_d;
    logic [DSZ-1:0] len_q, len_d;
    logic [DSZ-1:0] toin_q, toin_d;
    logic           nul_q, nul_d;
    logic           ovf_q, ovf_d;
    logic [DSZ-1:0] ch_q, ch_d;

    logic [DSZ-1:0] i_inc;
    logic           is_delim;

    assign i_inc = i_q + DSZ'(1);

`ifdef WORD_PARSER_WS_EN
    assign is_delim = (vw_i == delim_i) || ((delim_i == SPACE) && (vw_i <= SPACE));
`else
    assign is_delim = (vw_i == delim_i);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tib_q   <= '0;
            ntib_q  <= '0;
            i_q     <= '0;
            aw_q    <= '0;
            len_q   <= '0;
            toin_q  <= '0;
            nul_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            tib_q   <= tib_d;
            ntib_q  <= ntib_d;
            i_q     <= i_d;
            aw_q    <= aw_d;
            len_q   <= len_d;
            toin_q  <= toin_d;
            nul_q   <= nul_d;
            ovf_q   <= ovf_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tib_d   = tib_q;
        ntib_d  = ntib_q;
        i_d     = i_q;
        aw_d    = aw_q;
        len_d   = len_q;
        toin_d  = toin_q;
        nul_d   = nul_q;
        ovf_d   = ovf_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    tib_d   = tib_i;
                    ntib_d  = ntib_i;
                    i_d     = toi_i;
                    aw_d    = dst_i;
                    len_d   = '0;
                    nul_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (toi_i >= ntib_i) ? LEN_WR : SKP_RD;
                end
            end
            SKP_RD: state_d = SKP_CK;
            SKP_CK: begin
                i_d = i_inc;
                if (is_delim) begin
                    state_d = (i_inc == ntib_q) ? LEN_WR : SKP_RD;
                end else begin
                    ch_d    = vw_i;
                    state_d = CPY_WR;
                end
            end
            CPY_WR: begin
                // Characters past MAX_LEN are still consumed, just not stored.
                if (len_q < MAX_LEN_W) len_d = len_q + DSZ'(1);
                else                   ovf_d = 1'b1;
                state_d = (i_q == ntib_q) ? LEN_WR : CPY_RD;
            end
            CPY_RD: state_d = CPY_CK;
            CPY_CK: begin
                i_d = i_inc;
                if (is_delim) begin
                    state_d = LEN_WR;
                end else begin
                    ch_d    = vw_i;
                    state_d = CPY_WR;
                end
            end
            LEN_WR: begin
                nul_d   = (len_q == '0);
                toin_d  = i_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes decode straight from the state register so reset kills a write at once.
    always_comb begin
        mb_ai_o = '0;
        mb_vi_o = '0;
        mb_we_o = 1'b0;
        case (state_q)
            SKP_RD, CPY_RD: mb_ai_o = tib_q + {{(ASZ-DSZ){1'b0}}, i_q};
            CPY_WR: begin
                mb_ai_o = aw_q + ASZ'(1) + {{(ASZ-DSZ){1'b0}}, len_q};
                mb_vi_o = ch_q;
                mb_we_o = (len_q < MAX_LEN_W);
            end
            LEN_WR: begin
                mb_ai_o = aw_q;
                mb_vi_o = len_q;
                mb_we_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bsy_o   = (state_q != IDLE) && (state_q != DONE);
    assign done_o  = (state_q == DONE);
    assign aw_o    = aw_q;
    assign len_o   = len_q;
    assign toin_o  = toin_q;
    assign nul_o   = nul_q;
    assign ovf_o   = ovf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_word_parser.sv
// Directed bench for word_parser with a one-cycle-latency byte memory model.
module tb_word_parser;

    localparam int DSZ = 8;
    localparam int ASZ = 17;
    localparam int MAX_LEN = 31;
    localparam logic [ASZ-1:0] DST = 17'h100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic           we;
    logic [DSZ-1:0] vw = '0;
    logic           en = 1'b0;
    logic [ASZ-1:0] tib = '0;
    logic [DSZ-1:0] ntib = '0;
    logic [DSZ-1:0] toi = '0;
    logic [ASZ-1:0] dst = DST;
    logic [DSZ-1:0] delim = 8'h20;
    logic           bsy, done, nul, ovf;
    logic [ASZ-1:0] aw;
    logic [DSZ-1:0] len, toin;
    logic [2:0]     state;

    logic [7:0] mem [0:4095];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int edges;

    always #5 clk = ~clk;

    word_parser #(.DSZ(DSZ), .ASZ(ASZ), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .mb_ai_o(ai), .mb_vi_o(vi), .mb_we_o(we), .vw_i(vw),
        .en_i(en), .tib_i(tib), .ntib_i(ntib), .toi_i(toi), .dst_i(dst), .delim_i(delim),
        .bsy_o(bsy), .done_o(done), .aw_o(aw), .len_o(len), .toin_o(toin),
        .nul_o(nul), .ovf_o(ovf), .state_o(state)
    );

    always @(posedge clk) begin
        vw <= mem[ai[11:0]];
        if (we) mem[ai[11:0]] <= vi;
    end

    always @(negedge clk) if (done) done_cnt++;

    task clear_mem();
        for (int k = 0; k < 4096; k++) mem[k] = 8'hEE;
    endtask

    task load_tib(input string s);
        clear_mem();
        for (int k = 0; k < s.len(); k++) mem[k] = s[k];
    endtask

    // Starts a parse and returns the number of edges from the start edge (counted as 1) to DONE.
    task run(input logic [DSZ-1:0] n, input logic [DSZ-1:0] t, output int e);
        @(negedge clk);
        tib = '0; ntib = n; toi = t; dst = DST; en = 1'b1;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        en = 1'b0;
        while (!done && e < 500) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout: no done after %0d edges", e);
        end
    endtask

    task test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({bsy, done, nul, ovf, we} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {bsy, done, nul, ovf, we}); end
        n_cmp++; if (aw !== '0) begin n_bad++; $display("FAIL reset_aw: got %h want 0", aw); end
        n_cmp++; if ({len, toin} !== 16'h0) begin n_bad++; $display("FAIL reset_len_toin: got %h want 0000", {len, toin}); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task test_dup();
        load_tib(" DUP X");
        delim = 8'h20;
        run(8'd6, 8'd0, edges);
        n_cmp++; if (edges !== 15) begin n_bad++; $display("FAIL dup_latency: got %0d want 15", edges); end
        n_cmp++; if (len !== 8'd3) begin n_bad++; $display("FAIL dup_len: got %0d want 3", len); end
        n_cmp++; if (toin !== 8'd5) begin n_bad++; $display("FAIL dup_toin: got %0d want 5", toin); end
        n_cmp++; if ({nul, ovf} !== 2'b00) begin n_bad++; $display("FAIL dup_nul_ovf: got %b want 00", {nul, ovf}); end
        n_cmp++; if (aw !== DST) begin n_bad++; $display("FAIL dup_aw: got %h want %h", aw, DST); end
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL dup_bsy_in_done: got %b want 0", bsy); end
        @(negedge clk);
        n_cmp++;
        if ({mem[256], mem[257], mem[258], mem[259], mem[260]} !== {8'h03, "DUP", 8'hEE}) begin
            n_bad++;
            $display("FAIL dup_mem: got %h want 03445550ee", {mem[256], mem[257], mem[258], mem[259], mem[260]});
        end
    endtask

    task test_no_terminator();
        load_tib("AB");
        @(negedge clk);
        tib = '0; ntib = 8'd2; toi = 8'd0; dst = DST; en = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        en = 1'b0;
        while (!done && edges < 500) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            // A second strobe with different arguments while busy must be ignored.
            if (edges == 3) begin toi = 8'd1; dst = 17'h200; en = 1'b1; end
            else en = 1'b0;
        end
        en = 1'b0;
        n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL ab_latency: got %0d want 8", edges); end
        n_cmp++; if ({len, toin} !== {8'd2, 8'd2}) begin n_bad++; $display("FAIL ab_len_toin: got %h want 0202", {len, toin}); end
        n_cmp++; if (aw !== DST) begin n_bad++; $display("FAIL ab_aw_busy_en: got %h want %h", aw, DST); end
        @(negedge clk);
        n_cmp++;
        if ({mem[256], mem[257], mem[258]} !== {8'h02, "AB"}) begin
            n_bad++;
            $display("FAIL ab_mem: got %h want 024142", {mem[256], mem[257], mem[258]});
        end
    endtask

    task test_empty();
        load_tib("   ");
        run(8'd3, 8'd0, edges);
        n_cmp++; if ({len, toin} !== {8'd0, 8'd3}) begin n_bad++; $display("FAIL blank_len_toin: got %h want 0003", {len, toin}); end
        n_cmp++; if (nul !== 1'b1) begin n_bad++; $display("FAIL blank_nul: got %b want 1", nul); end
        @(negedge clk);
        n_cmp++; if (mem[256] !== 8'h00) begin n_bad++; $display("FAIL blank_mem: got %h want 00", mem[256]); end
        mem[256] = 8'hEE;
        run(8'd3, 8'd3, edges);
        n_cmp++; if (edges !== 2) begin n_bad++; $display("FAIL empty_latency: got %0d want 2", edges); end
        n_cmp++; if ({nul, len, toin} !== {1'b1, 8'd0, 8'd3}) begin n_bad++; $display("FAIL empty_result: got %h want 10003", {nul, len, toin}); end
        @(negedge clk);
        n_cmp++; if (mem[256] !== 8'h00) begin n_bad++; $display("FAIL empty_mem: got %h want 00", mem[256]); end
    endtask

    task test_overflow();
        int bad;
        clear_mem();
        for (int k = 0; k < 40; k++) mem[k] = 8'h61 + 8'(k % 26);
        mem[40] = 8'h20;
        run(8'd41, 8'd0, edges);
        n_cmp++; if (edges !== 124) begin n_bad++; $display("FAIL ovf_latency: got %0d want 124", edges); end
        n_cmp++; if ({ovf, len} !== {1'b1, 8'd31}) begin n_bad++; $display("FAIL ovf_len: got %h want 11f", {ovf, len}); end
        n_cmp++; if (toin !== 8'd41) begin n_bad++; $display("FAIL ovf_toin: got %0d want 41", toin); end
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 31; k++) if (mem[257 + k] !== 8'h61 + 8'(k % 26)) bad++;
        n_cmp++; if (bad != 0 || mem[256] !== 8'd31 || mem[288] !== 8'hEE) begin
            n_bad++;
            $display("FAIL ovf_mem: %0d wrong chars, len byte %h want 1f, byte after %h want ee", bad, mem[256], mem[288]);
        end
    endtask

    task test_reset_mid();
        int cnt0, w;
        load_tib("HELLO ");
        cnt0 = done_cnt;
        @(negedge clk);
        tib = '0; ntib = 8'd6; toi = 8'd0; dst = DST; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        w = 0;
        while (state !== 3'd3 && w < 20) begin @(negedge clk); w++; end
        n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL rstmid_we_before: got %b want 1", we); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({we, bsy, state} !== {1'b0, 1'b0, 3'd0}) begin n_bad++; $display("FAIL rstmid_async: got we=%b bsy=%b st=%0d want 0 0 0", we, bsy, state); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (done_cnt !== cnt0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - cnt0); end
        n_cmp++; if (mem[256] !== 8'hEE) begin n_bad++; $display("FAIL rstmid_no_len_byte: got %h want ee", mem[256]); end
        run(8'd6, 8'd0, edges);
        n_cmp++; if ({len, toin} !== {8'd5, 8'd6}) begin n_bad++; $display("FAIL rstmid_reparse: got %h want 0506", {len, toin}); end
        @(negedge clk);
        n_cmp++; if ({mem[256], mem[257], mem[261]} !== {8'h05, "H", "O"}) begin n_bad++; $display("FAIL rstmid_mem: got %h want 05484f", {mem[256], mem[257], mem[261]}); end
    endtask

    task test_whitespace();
        load_tib("\tX\n");
        delim = 8'h20;
        run(8'd3, 8'd0, edges);
`ifdef WORD_PARSER_WS_EN
        n_cmp++; if ({len, toin} !== {8'd1, 8'd3}) begin n_bad++; $display("FAIL ws_len_toin: got %h want 0103", {len, toin}); end
        @(negedge clk);
        n_cmp++; if ({mem[256], mem[257]} !== {8'h01, "X"}) begin n_bad++; $display("FAIL ws_mem: got %h want 0158", {mem[256], mem[257]}); end
`else
        n_cmp++; if ({len, toin} !== {8'd3, 8'd3}) begin n_bad++; $display("FAIL ws_len_toin: got %h want 0303", {len, toin}); end
        @(negedge clk);
        n_cmp++; if ({mem[256], mem[257], mem[258], mem[259]} !== {8'h03, 8'h09, "X", 8'h0A}) begin
            n_bad++;
            $display("FAIL ws_mem: got %h want 0309580a", {mem[256], mem[257], mem[258], mem[259]});
        end
`endif
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_dup();
        test_no_terminator();
        test_empty();
        test_overflow();
        test_dup();
        test_reset_mid();
        test_whitespace();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
